// File: rtl/gf180mcu_setn_seq_pkg.sv
// Shared types and limits for the gf180mcu SETN release sequencer.
package gf180mcu_setn_seq_pkg;

    localparam int CNT_W     = 4;
    localparam int GI_W      = 3;
    localparam int N_GRP_MIN = 1;
    localparam int N_GRP_MAX = 8;
    localparam int CYC_MIN   = 1;
    localparam int CYC_MAX   = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        SETTLE  = 2'd3
    } state_e;

    function automatic bit cyc_ok(input int v);
        return (v >= CYC_MIN) && (v <= CYC_MAX);
    endfunction

endpackage

// File: rtl/gf180mcu_setn_seq_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clock edge.
module gf180mcu_setn_seq_rst_sync (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_s_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_s_o = sync_q[1];

endmodule

// File: rtl/gf180mcu_setn_release_seq.sv
// Staggered SETN release sequencer for a dffsnq bank; holds the bank clock off while sequencing.
// Optional sticky request-while-busy flag (ERR/ERR_CLR) is built when SETN_SEQ_ERR_EN is defined.
module gf180mcu_setn_release_seq
    import gf180mcu_setn_seq_pkg::*;
#(
    parameter int N_GRP       = 4,
    parameter int PW_CYC      = 2,
    parameter int STAGGER_CYC = 1,
    parameter int SETTLE_CYC  = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_SET,
`ifdef SETN_SEQ_ERR_EN
    input  logic             ERR_CLR,
    output logic             ERR,
`endif
    output logic [N_GRP-1:0] SETN,
    output logic             CLK_EN,
    output logic             BUSY,
    output logic             DONE
);

    if (N_GRP < N_GRP_MIN || N_GRP > N_GRP_MAX || !cyc_ok(PW_CYC) ||
        !cyc_ok(STAGGER_CYC) || !cyc_ok(SETTLE_CYC)) begin : g_param_err
        $error("gf180mcu_setn_release_seq: parameter out of range");
    end

    localparam logic [CNT_W-1:0] PW_INIT      = CNT_W'(PW_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_INIT = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [GI_W-1:0]  GI_ONE       = GI_W'(1);
    localparam logic [GI_W-1:0]  GI_LAST      = GI_W'(N_GRP - 1);
    localparam logic [N_GRP-1:0] GRP0         = N_GRP'(1);

    logic rst_s;

    gf180mcu_setn_seq_rst_sync u_rst_sync (
        .clk_i   (CLK),
        .rst_i   (RST),
        .rst_s_o (rst_s)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GI_W-1:0]    gi_q, gi_d;
    logic [N_GRP-1:0]   setn_q, setn_d;
    logic               clk_en_q, clk_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ASSERT;
            cnt_q    <= PW_INIT;
            gi_q     <= '0;
            setn_q   <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gi_q     <= gi_d;
            setn_q   <= setn_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gi_d     = gi_q;
        setn_d   = setn_q;
        clk_en_d = clk_en_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        // Hold the full-assert state until the synchronized reset has released.
        if (rst_s) begin
            state_d  = ASSERT;
            cnt_d    = PW_INIT;
            gi_d     = '0;
            setn_d   = '0;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (REQ_SET) begin
                        state_d  = ASSERT;
                        cnt_d    = PW_INIT;
                        setn_d   = '0;
                        clk_en_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                ASSERT: begin
                    if (cnt_q == '0) begin
                        setn_d = setn_q | GRP0;
                        gi_d   = GI_ONE;
                        if (N_GRP == 1) begin
                            state_d = SETTLE;
                            cnt_d   = SETTLE_INIT;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = STAGGER_INIT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (cnt_q == '0) begin
                        setn_d = setn_q | (GRP0 << gi_q);
                        cnt_d  = STAGGER_INIT;
                        if (gi_q == GI_LAST) begin
                            state_d = SETTLE;
                            cnt_d   = SETTLE_INIT;
                        end else begin
                            gi_d = gi_q + GI_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                        // A pending request re-asserts on the DONE edge so the clock never reopens.
                        if (REQ_SET) begin
                            state_d = ASSERT;
                            cnt_d   = PW_INIT;
                            setn_d  = '0;
                        end else begin
                            state_d  = IDLE;
                            clk_en_d = 1'b1;
                            busy_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ASSERT;
                    cnt_d   = PW_INIT;
                    setn_d  = '0;
                end
            endcase
        end
    end

    assign SETN   = setn_q;
    assign CLK_EN = clk_en_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

`ifdef SETN_SEQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (REQ_SET && busy_q && !rst_s) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`endif

endmodule

// File: tb/tb_gf180mcu_setn_release_seq.sv
// Scoreboard bench for the SETN release sequencer: default instance A and a 1-group instance B.
module tb_gf180mcu_setn_release_seq;

    typedef struct packed {
        int         cyc;
        logic [3:0] setn;
        logic       clk_en;
        logic       busy;
        logic       done;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST_A = 1'b0, REQ_A = 1'b0, RST_B = 1'b0, REQ_B = 1'b0;
    logic [3:0] SETN_A;
    logic [0:0] SETN_B;
    logic       CLK_EN_A, BUSY_A, DONE_A, CLK_EN_B, BUSY_B, DONE_B;
`ifdef SETN_SEQ_ERR_EN
    logic       ERR_CLR_A = 1'b0, ERR_A, ERR_B;
`endif

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_a[$];
    ev_t exp_b[$];
    ev_t prev_a, prev_b, cur_a, cur_b;

    gf180mcu_setn_release_seq u_dut_a (
        .CLK     (CLK),
        .RST     (RST_A),
        .REQ_SET (REQ_A),
`ifdef SETN_SEQ_ERR_EN
        .ERR_CLR (ERR_CLR_A),
        .ERR     (ERR_A),
`endif
        .SETN    (SETN_A),
        .CLK_EN  (CLK_EN_A),
        .BUSY    (BUSY_A),
        .DONE    (DONE_A)
    );

    gf180mcu_setn_release_seq #(
        .N_GRP       (1),
        .PW_CYC      (1),
        .STAGGER_CYC (3),
        .SETTLE_CYC  (1)
    ) u_dut_b (
        .CLK     (CLK),
        .RST     (RST_B),
        .REQ_SET (REQ_B),
`ifdef SETN_SEQ_ERR_EN
        .ERR_CLR (1'b0),
        .ERR     (ERR_B),
`endif
        .SETN    (SETN_B),
        .CLK_EN  (CLK_EN_B),
        .BUSY    (BUSY_B),
        .DONE    (DONE_B)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic [3:0] s, input logic ce,
                               input logic b, input logic d);
        ev_t e;
        e.cyc = c; e.setn = s; e.clk_en = ce; e.busy = b; e.done = d;
        return e;
    endfunction

    function automatic logic [6:0] outs(input ev_t e);
        return {e.setn, e.clk_en, e.busy, e.done};
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, got, exp);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t got, input ev_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cyc=%0d setn=%b clk_en=%b busy=%b done=%b, expected cyc=%0d setn=%b clk_en=%b busy=%b done=%b",
                     nm, got.cyc, got.setn, got.clk_en, got.busy, got.done,
                     exp.cyc, exp.setn, exp.clk_en, exp.busy, exp.done);
        end
    endtask

    // SETN must be a thermometer code, never partially re-asserted, and the clock stays off until all groups are released.
    task automatic inv(input string nm, input ev_t cur, input ev_t prev, input logic [3:0] full);
        logic [3:0] inc;
        logic       ok;
        inc = cur.setn + 4'd1;
        ok  = ((cur.setn & inc) == 4'd0) &&
              !(cur.clk_en && (cur.setn != full)) &&
              ((cur.setn == 4'd0) || ((prev.setn & ~cur.setn) == 4'd0));
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_invariant: cyc=%0d setn=%b prev=%b clk_en=%b", nm, cur.cyc,
                     cur.setn, prev.setn, cur.clk_en);
        end
    endtask

    initial begin
        prev_a = mk(0, 4'b0000, 1'b0, 1'b1, 1'b0);
        prev_b = prev_a;
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            cur_a = mk(cyc, SETN_A, CLK_EN_A, BUSY_A, DONE_A);
            inv("A", cur_a, prev_a, 4'b1111);
            if (outs(cur_a) !== outs(prev_a)) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL A_unexpected: cyc=%0d setn=%b clk_en=%b busy=%b done=%b, expected no change",
                             cur_a.cyc, cur_a.setn, cur_a.clk_en, cur_a.busy, cur_a.done);
                end else begin
                    cmp_ev("A_event", cur_a, exp_a.pop_front());
                end
            end
            prev_a = cur_a;
        end
    end

    always @(negedge CLK) begin
        if (cyc > 0) begin
            cur_b = mk(cyc, {3'b000, SETN_B}, CLK_EN_B, BUSY_B, DONE_B);
            inv("B", cur_b, prev_b, 4'b0001);
            if (outs(cur_b) !== outs(prev_b)) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL B_unexpected: cyc=%0d setn=%b clk_en=%b busy=%b done=%b, expected no change",
                             cur_b.cyc, cur_b.setn, cur_b.clk_en, cur_b.busy, cur_b.done);
                end else begin
                    cmp_ev("B_event", cur_b, exp_b.pop_front());
                end
            end
            prev_b = cur_b;
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic push_a(input int c, input logic [3:0] s, input logic ce, input logic b, input logic d);
        exp_a.push_back(mk(c, s, ce, b, d));
    endtask

    task automatic push_b(input int c, input logic s, input logic ce, input logic b, input logic d);
        exp_b.push_back(mk(c, {3'b000, s}, ce, b, d));
    endtask

    task automatic ramp_a(input int e0);
        push_a(e0 + 2, 4'b0001, 1'b0, 1'b1, 1'b0);
        push_a(e0 + 3, 4'b0011, 1'b0, 1'b1, 1'b0);
        push_a(e0 + 4, 4'b0111, 1'b0, 1'b1, 1'b0);
        push_a(e0 + 5, 4'b1111, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle_a(input int e0);
        push_a(e0 + 7, 4'b1111, 1'b1, 1'b0, 1'b1);
        push_a(e0 + 8, 4'b1111, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic req_a(input int e0);
        push_a(e0, 4'b0000, 1'b0, 1'b1, 1'b0);
        ramp_a(e0);
        idle_a(e0);
    endtask

    initial begin
        #1;
        RST_A = 1'b1;
        RST_B = 1'b1;
        #2;
        chk("A_reset_setn", {4'b0, SETN_A}, 8'h00);
        chk("A_reset_clk_en", {7'b0, CLK_EN_A}, 8'h00);
        chk("A_reset_busy", {7'b0, BUSY_A}, 8'h01);
        chk("A_reset_done", {7'b0, DONE_A}, 8'h00);
        chk("B_reset_setn", {7'b0, SETN_B}, 8'h00);
        chk("B_reset_busy", {7'b0, BUSY_B}, 8'h01);

        // Power-up: reset released after edge 3, so rst_s falls at edge 5.
        ramp_a(5);
        idle_a(5);
        push_b(6, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(7, 1'b1, 1'b1, 1'b0, 1'b1);
        push_b(8, 1'b1, 1'b1, 1'b0, 1'b0);
        goto(3);
        RST_A = 1'b0;
        RST_B = 1'b0;

        // Single-group instance re-requested from IDLE at edge 11.
        push_b(11, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(12, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(13, 1'b1, 1'b1, 1'b0, 1'b1);
        push_b(14, 1'b1, 1'b1, 1'b0, 1'b0);
        goto(10); REQ_B = 1'b1;
        goto(11); REQ_B = 1'b0;

        // One-cycle request from IDLE, E0 = 16.
        req_a(16);
        goto(15); REQ_A = 1'b1;
        goto(16); REQ_A = 1'b0;

        // Requests at E3 and E6 of a running sequence are ignored, E0 = 27.
        req_a(27);
        goto(26); REQ_A = 1'b1;
        goto(27); REQ_A = 1'b0;
`ifdef SETN_SEQ_ERR_EN
        goto(29);
        chk("A_err_clear_before", {7'b0, ERR_A}, 8'h00);
`endif
        goto(29); REQ_A = 1'b1;
        goto(30); REQ_A = 1'b0;
`ifdef SETN_SEQ_ERR_EN
        chk("A_err_set", {7'b0, ERR_A}, 8'h01);
`endif
        goto(32); REQ_A = 1'b1;
        goto(33); REQ_A = 1'b0;
`ifdef SETN_SEQ_ERR_EN
        goto(34); ERR_CLR_A = 1'b1;
        goto(35); ERR_CLR_A = 1'b0;
        chk("A_err_cleared", {7'b0, ERR_A}, 8'h00);
`endif

        // Async reset between E3 and E4 of a sequence started at E0 = 38.
        push_a(38, 4'b0000, 1'b0, 1'b1, 1'b0);
        push_a(40, 4'b0001, 1'b0, 1'b1, 1'b0);
        push_a(41, 4'b0011, 1'b0, 1'b1, 1'b0);
        push_a(42, 4'b0000, 1'b0, 1'b1, 1'b0);
        ramp_a(45);
        idle_a(45);
        goto(37); REQ_A = 1'b1;
        goto(38); REQ_A = 1'b0;
        goto(41);
        #5;
        RST_A = 1'b1;
        #1;
        chk("A_async_rst_setn", {4'b0, SETN_A}, 8'h00);
        chk("A_async_rst_busy", {7'b0, BUSY_A}, 8'h01);
        chk("A_async_rst_clk_en", {7'b0, CLK_EN_A}, 8'h00);
        goto(43); RST_A = 1'b0;

        // REQ_SET held: restart on the DONE edge (64) with no CLK_EN gap.
        push_a(57, 4'b0000, 1'b0, 1'b1, 1'b0);
        ramp_a(57);
        push_a(64, 4'b0000, 1'b0, 1'b1, 1'b1);
        push_a(65, 4'b0000, 1'b0, 1'b1, 1'b0);
        ramp_a(64);
        idle_a(64);
        goto(56); REQ_A = 1'b1;
        goto(66); REQ_A = 1'b0;

        goto(80);
        chk("A_scoreboard_drained", 8'(exp_a.size()), 8'h00);
        chk("B_scoreboard_drained", 8'(exp_b.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
